// File: rtl/servo_move_sequencer.sv
// rtl/servo_move_sequencer.sv - one-move-at-a-time servo duty ramp sequencer
module servo_move_sequencer #(
   parameter int N_SERVO       = 6,
   parameter int PERIOD        = 1000000,
   parameter int STEP          = 500,
   parameter int SETTLE_FRAMES = 10,
   parameter int D_MIN         = 50000,
   parameter int D_MAX         = 125000,
   parameter int D_INIT        = 75000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_servo,
   input  logic [31:0]            cmd_duty,
   output logic [32*N_SERVO-1:0]  duty_flat,
   output logic [31:0]            t,
   output logic                   frame_tick,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam logic [31:0] PERIOD32 = 32'(PERIOD);
   localparam logic [31:0] STEP32   = 32'(STEP);
   localparam logic [32:0] STEP33   = {1'b0, STEP32};
   localparam logic [31:0] SETTLE32 = 32'(SETTLE_FRAMES);
   localparam logic [31:0] DMIN32   = 32'(D_MIN);
   localparam logic [31:0] DMAX32   = 32'(D_MAX);
   localparam logic [31:0] DINIT32  = 32'(D_INIT);
   localparam logic [3:0]  NSERVO4  = 4'(N_SERVO);

   typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

   state_t      state;
   logic [31:0] frame_cnt;
   logic [31:0] settle_cnt;
   logic [2:0]  sel;
   logic [31:0] target;
   logic [31:0] duty [N_SERVO];
   logic [31:0] cur;
   logic [31:0] clamped;
   logic [32:0] diff;
   logic [32:0] mag;

   assign t          = PERIOD32;
   assign frame_tick = (frame_cnt == PERIOD32 - 32'd1);

   for (genvar i = 0; i < N_SERVO; i++) begin : g_flat
      assign duty_flat[32*i +: 32] = duty[i];
   end

   always_comb begin
      cur = '0;
      for (int i = 0; i < N_SERVO; i++) begin
         if (sel == 3'(i)) cur = duty[i];
      end
   end

   assign clamped = (cmd_duty < DMIN32) ? DMIN32 :
                    (cmd_duty > DMAX32) ? DMAX32 : cmd_duty;

   // 33-bit signed-style difference; bit 32 set means target is below cur
   assign diff = {1'b0, target} - {1'b0, cur};
   assign mag  = diff[32] ? (33'd0 - diff) : diff;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         frame_cnt  <= '0;
         settle_cnt <= '0;
         sel        <= '0;
         target     <= DINIT32;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         for (int i = 0; i < N_SERVO; i++) duty[i] <= DINIT32;
      end else begin
         frame_cnt <= frame_tick ? '0 : frame_cnt + 32'd1;
         done      <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               // ticks are ignored here, so a tick on the accept edge never steps
               if (cmd_valid && cmd_ready) begin
                  if ({1'b0, cmd_servo} >= NSERVO4) begin
                     err <= 1'b1;
                  end else begin
                     sel       <= cmd_servo;
                     target    <= clamped;
                     state     <= RAMP;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            RAMP: begin
               if (frame_tick) begin
                  for (int i = 0; i < N_SERVO; i++) begin
                     if (sel == 3'(i)) begin
                        if (mag <= STEP33)  duty[i] <= target;
                        else if (!diff[32]) duty[i] <= cur + STEP32;
                        else                duty[i] <= cur - STEP32;
                     end
                  end
                  if (mag <= STEP33) begin
                     settle_cnt <= '0;
                     state      <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (frame_tick) begin
                  settle_cnt <= settle_cnt + 32'd1;
                  if (settle_cnt + 32'd1 == SETTLE32) begin
                     state     <= IDLE;
                     done      <= 1'b1;
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servo_move_sequencer.sv
// tb/tb_servo_move_sequencer.sv - randomized bench for servo_move_sequencer against a move-level model
module tb_servo_move_sequencer;

   localparam int N      = 6;
   localparam int PERIOD = 10;
   localparam int STEP   = 100;
   localparam int SETTLE = 2;
   localparam int DMIN   = 1000;
   localparam int DMAX   = 2000;
   localparam int DINIT  = 1500;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [2:0]      cmd_servo = '0;
   logic [31:0]     cmd_duty = '0;
   logic [32*N-1:0] duty_flat;
   logic [31:0]     t;
   logic            frame_tick;
   logic            busy;
   logic            done;
   logic            err;

   servo_move_sequencer #(
      .N_SERVO(N), .PERIOD(PERIOD), .STEP(STEP), .SETTLE_FRAMES(SETTLE),
      .D_MIN(DMIN), .D_MAX(DMAX), .D_INIT(DINIT)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_servo(cmd_servo), .cmd_duty(cmd_duty), .duty_flat(duty_flat),
      .t(t), .frame_tick(frame_tick), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int model [N];
   int mcnt = 0;
   int done_cnt = 0;
   logic [32*N-1:0] prev_flat;
   logic prev_tick = 1'b0;
   logic prev_rst = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // frame position seen from outside: cycles since reset release, modulo PERIOD
   always @(posedge clk or negedge reset) begin
      if (!reset) mcnt <= 0;
      else        mcnt <= (mcnt == PERIOD - 1) ? 0 : mcnt + 1;
   end

   always @(negedge clk) begin
      if (reset) check("frame_tick", frame_tick, (mcnt == PERIOD - 1));
      if (reset && prev_rst && duty_flat !== prev_flat) check("duty_on_tick", prev_tick, 1);
      prev_flat <= duty_flat;
      prev_tick <= frame_tick;
      prev_rst  <= reset;
      if (done) done_cnt <= done_cnt + 1;
   end

   function automatic int clampd(input int d);
      return (d < DMIN) ? DMIN : (d > DMAX) ? DMAX : d;
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < N; i++) check(tag, duty_flat[32*i +: 32], model[i]);
   endtask

   task automatic wait_tick(output bit ok, output int cyc);
      ok = 0;
      cyc = 0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
         @(negedge clk);
         cyc++;
         if (frame_tick) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("tick_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_move(input int s, input int d, input bit on_tick,
                          input bit hold_next, input int ns, input int nd);
      int tgt, start, diff, adiff, nramp, e, snap, cyc;
      bit ok;
      if (on_tick) begin
         for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (frame_tick) break;
         end
      end
      cmd_servo = s[2:0];
      cmd_duty  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("accept_busy", busy, 1);
      check("accept_ready", cmd_ready, 0);
      check("accept_err", err, 0);
      snap = done_cnt;
      if (hold_next) begin
         cmd_servo = ns[2:0];
         cmd_duty  = nd;
         cmd_valid = 1'b1;
      end
      tgt   = clampd(d);
      start = model[s];
      diff  = tgt - start;
      adiff = (diff < 0) ? -diff : diff;
      nramp = (adiff + STEP - 1) / STEP;
      if (nramp < 1) nramp = 1;
      for (int k = 1; k <= nramp; k++) begin
         wait_tick(ok, cyc);
         if (!ok) return;
         if (k == 1 && on_tick) check("tick_accept_delay", cyc, PERIOD);
         e = (k * STEP >= adiff) ? adiff : k * STEP;
         model[s] = start + ((diff < 0) ? -e : e);
         check_all("ramp_duty");
         check("ramp_busy", busy, 1);
         check("ramp_ready", cmd_ready, 0);
      end
      for (int k = 1; k <= SETTLE; k++) begin
         wait_tick(ok, cyc);
         if (!ok) return;
         check("settle_done", done, (k == SETTLE));
      end
      check("done_ready", cmd_ready, 1);
      check("done_busy", busy, 0);
      check("no_early_done", done_cnt, snap);
      check_all("final_duty");
      if (!hold_next) begin
         @(posedge clk);
         #1;
         check("done_pulse_len", done, 0);
      end
   endtask

   task automatic reject(input int s);
      cmd_servo = s[2:0];
      cmd_duty  = $urandom_range(0, 3000);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("rej_err", err, 1);
      check("rej_ready", cmd_ready, 1);
      check("rej_busy", busy, 0);
      check_all("rej_duty");
      @(posedge clk);
      #1;
      check("rej_err_len", err, 0);
   endtask

   initial begin
      int cyc, snap;
      bit ok;
      for (int i = 0; i < N; i++) model[i] = DINIT;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset_duty");
      check("reset_ready", cmd_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_tick", frame_tick, 0);
      check("t_value", t, PERIOD);
      @(negedge clk);
      #2 reset = 1'b1;
      wait_tick(ok, cyc);
      check("first_tick_gap", cyc, PERIOD - 1);
      wait_tick(ok, cyc);
      check("tick_gap", cyc, PERIOD);

      do_move(2, 1750, 0, 0, 0, 0);
      do_move(0, 10, 0, 0, 0, 0);
      do_move(5, 5000, 0, 0, 0, 0);
      reject(6);
      reject(7);
      do_move(1, 1300, 0, 1, 4, 1900);
      do_move(4, 1900, 0, 0, 0, 0);
      do_move(3, 1500, 0, 0, 0, 0);
      do_move(2, 1200, 1, 0, 0, 0);

      // abort a ramp with reset, then confirm a clean restart
      cmd_servo = 3'd3;
      cmd_duty  = 2000;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_tick(ok, cyc);
      model[3] = 1600;
      check_all("abort_ramp1");
      wait_tick(ok, cyc);
      model[3] = 1700;
      check_all("abort_ramp2");
      snap = done_cnt;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < N; i++) model[i] = DINIT;
      check_all("abort_duty");
      check("abort_busy", busy, 0);
      check("abort_ready", cmd_ready, 1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, snap);
      check("abort_done", done, 0);
      do_move(3, 1650, 0, 0, 0, 0);

      for (int r = 0; r < 14; r++) begin
         int s;
         s = $urandom_range(0, 7);
         if (s >= N) reject(s);
         else do_move(s, $urandom_range(0, 3000), 1'($urandom_range(0, 1)), 0, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
